inv_converter_pipe: RTL and testbench
=====================================

Name: inv_converter_pipe

Overview:
- Parametrised, pipelined two's-complement negate/absolute-value unit.
- Generalises the 16-bit combinational negator to DATA_W bits.
- The +1 carry chain is split into SEG_W-bit segments, with one register stage per segment, so the carry never crosses a whole word in one cycle.
- Sits ahead of the Booth multiplier operand path; uses a valid/ready handshake with backpressure.

Parameters:
- DATA_W, 16, operand width in bits (>=2).
- SEG_W, 4, bits incremented per pipeline stage (1..DATA_W).
- NSTAGE, derived = ceil(DATA_W/SEG_W). Not overridable; it is the latency in cycles.

Ports:
- sys_clk  input  1  clock; all state updates on its rising edge.
- sys_rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  unit accepts input this cycle.
- data_i  input  DATA_W  two's-complement operand.
- mode_i  input  2  00 pass, 01 negate, 10 abs, 11 pass (reserved).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- data_o  output  DATA_W  result.
- ovf_o  output  1  result overflowed (see Behaviour); qualified by out_valid.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - All stage valid bits, out_valid, data_o and ovf_o clear to 0.
  - in_ready reads 1 during the first cycle after reset.
  - A reset mid-operation discards all in-flight words. No partial output appears.
- Handshake:
  - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
  - Global stall: adv = ~out_valid | out_ready; in_ready = adv.
  - When adv=0, every stage register holds its value, including bubbles.
  - When adv=1, every stage shifts one place. A bubble (valid 0) enters when in_valid=0.
  - Throughput is one word per cycle while out_ready=1.
- Latency: a word accepted at edge k appears on data_o/out_valid after edge k+NSTAGE-1, given no stall. Each stall cycle adds one cycle.
- Stage 0, at acceptance:
  - neg = (mode==01) | (mode==10 & data_i[DATA_W-1]).
  - Register x = neg ? ~data_i : data_i, with cin = neg.
  - Register ovf = neg & (data_i == 1 followed by DATA_W-1 zeros).
- Stage s (0..NSTAGE-1):
  - Add the carry into bits [s*SEG_W +: SEG_W] of x. The last segment is clipped to DATA_W.
  - Pass the carry-out to stage s+1. Later segments pass through unchanged.
  - Stage 0 both inverts and increments segment 0.
- The carry-out of the final segment is discarded, so modulo-2^DATA_W arithmetic applies.
  - Negating 0 gives 0, ovf 0.
  - Negating the most negative value gives the most negative value, ovf 1 (wrap).
- mode 00/11: data_o = data_i, ovf 0.
- mode 10 with a non-negative input: data_o = data_i, ovf 0.
- Mode is sampled only at acceptance and travels with its word. Changing mode_i between words has no effect on in-flight words.
- data_o holds stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: INV_CONV_SATURATE_EN.
- Defined: when ovf is set, data_o = 0 followed by DATA_W-1 ones (max positive), and ovf_o=1.
- Undefined: wraps as above (data_o = min negative), and ovf_o=1.
- Latency and handshake are identical in both builds. Saturation is applied in the final stage.

Test Plan (DATA_W=16, SEG_W=4, so NSTAGE=4):
- Reset then mode 01, data_i 0x0001, out_ready=1 -> data_o 0xFFFF, ovf 0, out_valid exactly 3 edges after acceptance (NSTAGE-1); in_ready=1 throughout.
- Back-to-back negate of 0x0000, 0x7FFF, 0x00FF, 0xFFFF -> 0x0000, 0x8001, 0xFF01, 0x0001 on consecutive cycles. Checks the carry ripple across all segments for 0x0000.
- mode 10 on 0x8000 -> 0x8000 with ovf 1 (no macro), 0x7FFF with ovf 1 (macro defined). mode 10 on 0xFFFE -> 0x0002. mode 10 on 0x1234 -> 0x1234.
- Stream 6 words with out_ready low for 5 cycles mid-stream -> in_ready low during the stall, data_o stable, no word lost or duplicated, order preserved.
- Mixed modes per word (00 on 0xABCD, 01 on 0xABCD, 11 on 0x8000) -> 0xABCD, 0x5433, 0x8000 with ovf 0 on all three.
- Assert sys_rst_n=0 for one cycle with 3 words in flight -> out_valid 0 next cycle, no stale word emitted afterwards, a fresh word is processed with normal latency.

Source files
------------

// File: rtl/inv_converter_pipe.sv
// Pipelined two's-complement negate/abs unit; the +1 carry ripples one SEG_W-bit segment per stage.
// Optional build macro INV_CONV_SATURATE_EN clamps overflowed results to max positive instead of wrapping.
module inv_converter_pipe #(
    parameter int DATA_W = 16,
    parameter int SEG_W  = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        mode_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_o,
    output logic              ovf_o
);

    localparam int NSTAGE = (DATA_W + SEG_W - 1) / SEG_W;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef INV_CONV_SATURATE_EN
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
`endif

    // Adds cin into segment seg of x only; bits above DATA_W clip the last segment. Returns {cout, x'}.
    function automatic logic [DATA_W:0] inc_seg(input logic [DATA_W-1:0] x,
                                                 input logic cin,
                                                 input int seg);
        logic              c;
        logic [DATA_W-1:0] y;
        c = cin;
        y = x;
        for (int i = 0; i < DATA_W; i++) begin
            if ((i >= seg * SEG_W) && (i < (seg + 1) * SEG_W)) begin
                y[i] = x[i] ^ c;
                c    = x[i] & c;
            end
        end
        return {c, y};
    endfunction

    logic [NSTAGE-1:0]             r_vld;
    logic [NSTAGE-1:0]             r_cin;
    logic [NSTAGE-1:0]             r_ovf;
    logic [NSTAGE-1:0][DATA_W-1:0] r_x;

    logic [NSTAGE-1:0]             w_vld_nxt;
    logic [NSTAGE-1:0]             w_cin_nxt;
    logic [NSTAGE-1:0]             w_ovf_nxt;
    logic [NSTAGE-1:0][DATA_W-1:0] w_x_nxt;
    logic [DATA_W:0]               w_sum;
    logic                          w_adv;
    logic                          w_neg;
    logic                          w_unused_cout;

    // One global stall: the whole pipe, bubbles included, freezes while the output is blocked.
    assign w_adv     = ~r_vld[NSTAGE-1] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[NSTAGE-1];
    assign data_o    = r_x[NSTAGE-1];
    assign ovf_o     = r_ovf[NSTAGE-1];

    // The final segment's carry-out is dropped, giving modulo-2^DATA_W arithmetic.
    assign w_unused_cout = r_cin[NSTAGE-1];

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_vld_nxt = '0;
        w_cin_nxt = '0;
        w_ovf_nxt = '0;
        w_x_nxt   = '0;
        w_sum     = '0;

        w_neg        = (mode_i == 2'b01) || ((mode_i == 2'b10) && data_i[DATA_W-1]);
        w_vld_nxt[0] = in_valid;
        w_ovf_nxt[0] = w_neg && (data_i == MIN_NEG);
        w_sum        = inc_seg(w_neg ? ~data_i : data_i, w_neg, 0);
        w_cin_nxt[0] = w_sum[DATA_W];
        w_x_nxt[0]   = w_sum[DATA_W-1:0];

        for (int s = 1; s < NSTAGE; s++) begin
            w_vld_nxt[s] = r_vld[s-1];
            w_ovf_nxt[s] = r_ovf[s-1];
            w_sum        = inc_seg(r_x[s-1], r_cin[s-1], s);
            w_cin_nxt[s] = w_sum[DATA_W];
            w_x_nxt[s]   = w_sum[DATA_W-1:0];
        end

`ifdef INV_CONV_SATURATE_EN
        if (w_ovf_nxt[NSTAGE-1]) begin
            w_x_nxt[NSTAGE-1] = MAX_POS;
        end
`endif
    end

    // NOTE: state uses non-blocking assignments so every stage samples the pre-edge values of its neighbour.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_vld <= '0;
            r_cin <= '0;
            r_ovf <= '0;
            r_x   <= '0;
        end else if (w_adv) begin
            r_vld <= w_vld_nxt;
            r_cin <= w_cin_nxt;
            r_ovf <= w_ovf_nxt;
            r_x   <= w_x_nxt;
        end
    end

endmodule

// File: tb/tb_inv_converter_pipe.sv
// Scoreboard bench for inv_converter_pipe (DATA_W=16, SEG_W=4); expectations follow INV_CONV_SATURATE_EN.
module tb_inv_converter_pipe;

    localparam int DATA_W = 16;
    localparam int SEG_W  = 4;
    localparam int NSTAGE = 4;
`ifdef INV_CONV_SATURATE_EN
    localparam logic [15:0] OVF_VAL = 16'h7FFF;
`else
    localparam logic [15:0] OVF_VAL = 16'h8000;
`endif

    typedef struct {
        logic [15:0] d;
        logic        o;
        bit          lat;
        int          cyc;
    } exp_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_i;
    logic [1:0]  mode_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_o;
    logic        ovf_o;

    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;

    inv_converter_pipe #(.DATA_W(DATA_W), .SEG_W(SEG_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_i    (data_i),
        .mode_i    (mode_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .ovf_o     (ovf_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on each output transfer, checks hold value and stall readiness otherwise.
    always @(negedge sys_clk) begin
        if (sys_rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", out_valid, 0);
            end else if (out_ready) begin
                exp_t e;
                e = sb.pop_front();
                check("data_o", data_o, e.d);
                check("ovf_o", ovf_o, e.o);
                if (e.lat) check("latency", cyc, e.cyc);
            end else begin
                check("hold_data_o", data_o, sb[0].d);
                check("stall_in_ready", in_ready, 0);
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [1:0] m,
                        input logic [15:0] ed, input logic eo, input bit lat);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        data_i   = d;
        mode_i   = m;
        n        = 0;
        @(negedge sys_clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge sys_clk);
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
        end else begin
            e.d   = ed;
            e.o   = eo;
            e.lat = lat;
            e.cyc = cyc + 1 + NSTAGE - 1;
            sb.push_back(e);
            @(posedge sys_clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            n++;
            @(negedge sys_clk);
        end
        check("drain_empty", sb.size(), 0);
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        data_i    = '0;
        mode_i    = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        @(negedge sys_clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_o", data_o, 0);
        check("rst_ovf_o", ovf_o, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge sys_clk);
        #1;

        // Single negate: result exactly NSTAGE-1 edges after acceptance.
        send(16'h0001, 2'b01, 16'hFFFF, 1'b0, 1'b1);
        for (int i = 0; i < NSTAGE; i++) begin
            @(negedge sys_clk);
            check("t1_in_ready", in_ready, 1);
            check("t1_out_valid", out_valid, (i == NSTAGE - 1) ? 1 : 0);
        end
        drain();

        // Back-to-back negates, full carry ripple for zero.
        send(16'h0000, 2'b01, 16'h0000, 1'b0, 1'b1);
        send(16'h7FFF, 2'b01, 16'h8001, 1'b0, 1'b1);
        send(16'h00FF, 2'b01, 16'hFF01, 1'b0, 1'b1);
        send(16'hFFFF, 2'b01, 16'h0001, 1'b0, 1'b1);
        drain();

        // Absolute value, including the wrap/saturate case.
        send(16'h8000, 2'b10, OVF_VAL,  1'b1, 1'b0);
        send(16'hFFFE, 2'b10, 16'h0002, 1'b0, 1'b0);
        send(16'h1234, 2'b10, 16'h1234, 1'b0, 1'b0);
        send(16'h8000, 2'b01, OVF_VAL,  1'b1, 1'b0);
        drain();

        // Six-word stream with a five-cycle output stall mid-stream.
        fork
            begin
                send(16'h0001, 2'b01, 16'hFFFF, 1'b0, 1'b0);
                send(16'h0002, 2'b01, 16'hFFFE, 1'b0, 1'b0);
                send(16'h0003, 2'b01, 16'hFFFD, 1'b0, 1'b0);
                send(16'h0004, 2'b01, 16'hFFFC, 1'b0, 1'b0);
                send(16'h0005, 2'b01, 16'hFFFB, 1'b0, 1'b0);
                send(16'h0006, 2'b01, 16'hFFFA, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge sys_clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge sys_clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Per-word modes, reserved mode passes through.
        send(16'hABCD, 2'b00, 16'hABCD, 1'b0, 1'b1);
        send(16'hABCD, 2'b01, 16'h5433, 1'b0, 1'b1);
        send(16'h8000, 2'b11, 16'h8000, 1'b0, 1'b1);
        drain();

        // Reset with three words in flight: none may emerge.
        send(16'h1111, 2'b01, 16'hEEEF, 1'b0, 1'b0);
        send(16'h2222, 2'b01, 16'hDDDE, 1'b0, 1'b0);
        send(16'h3333, 2'b01, 16'hCCCD, 1'b0, 1'b0);
        sys_rst_n = 1'b0;
        sb.delete();
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rst_flush_valid", out_valid, 0);
        check("rst_flush_in_ready", in_ready, 1);
        repeat (8) @(posedge sys_clk);
        #1;
        send(16'h0010, 2'b01, 16'hFFF0, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
